collision_arbiter: RTL and testbench
====================================

// Module: collision_arbiter
//
// PURPOSE
//   Serialises velocity updates from per-ball border-collision units onto the single
//   velocity-bank write port. Collisions assert for many pixels while drawing requests
//   overlap; this block therefore accepts one collision per ball per frame.
//   Simultaneous requests are granted round-robin, one write every 2 cycles.
//   Sits between the border-collision instances and the ball velocity register bank.
//   Also drives the hit-sound trigger.
//
// PARAMETERS
//   NUM_BALLS  4   number of requesters/balls (>=2)
//   VEL_W      11  signed velocity width
//
// PORTS
//   clk            in   1                  system clock
//   resetN         in   1                  async active-low reset
//   startOfFrame   in   1                  1-cycle pulse; clears per-ball locks
//   reqValid       in   NUM_BALLS          bit i = ball i collision (level, may persist)
//   reqVelX        in   NUM_BALLS*VEL_W    packed signed new X vel, slice i = ball i
//   reqVelY        in   NUM_BALLS*VEL_W    packed signed new Y vel
//   wrEn           out  1                  1-cycle velocity-bank write strobe
//   wrIdx          out  $clog2(NUM_BALLS)  ball index being written
//   wrVelX         out  VEL_W              signed X vel to write
//   wrVelY         out  VEL_W              signed Y vel to write
//   hitSound       out  1                  1-cycle pulse, coincident with wrEn
//   busy           out  1                  |pend or state!=IDLE
//
// BEHAVIOUR
//   Reset (async, immediate):
//   - pend, lock, slots, grantIdx = 0; ptr = NUM_BALLS-1; state = IDLE.
//   - wrEn, wrIdx, wrVelX, wrVelY, hitSound, busy = 0.
//   Capture (per ball i, each edge):
//   - if reqValid[i] & !pend[i] & !lock[i]: pend[i]<=1; slot[i]<=reqVelX/Y slice i.
//   - Otherwise the request is ignored. A held request never overwrites a latched slot.
//   FSM (registered outputs):
//   - IDLE: if pend!=0, grantIdx <= first set pend bit searching ptr+1, ptr+2, ...,
//     wrapping mod NUM_BALLS; -> WRITE. A request captured on the same edge is not
//     visible until the next cycle.
//   - WRITE: wrEn<=1, hitSound<=1, wrIdx<=grantIdx, wrVel<=slot[grantIdx];
//     pend[grantIdx]<=0; lock[grantIdx]<=1; ptr<=grantIdx; -> IDLE.
//   - wrEn/hitSound default 0 every other cycle. wrVel/wrIdx hold their last value.
//   Latency and throughput:
//   - reqValid sampled at edge t -> wrEn high in cycle t+3.
//   - Max throughput is 1 write / 2 cycles. Worst-case drain of N pending is 2N cycles.
//   Locks and frames:
//   - startOfFrame clears all locks. It has priority over a lock set by a same-edge
//     WRITE, so that ball is unlocked after the edge.
//   - pend is NOT cleared by startOfFrame; pending writes complete in the next frame.
//   - Capture uses pre-edge lock: a req on the startOfFrame cycle for a locked ball is ignored.
//   - Capture in the same cycle that ball's WRITE edge occurs: pend[i] is still 1 pre-edge,
//     so the request is ignored.
//   Arithmetic and width:
//   - Velocities pass through unmodified (no negation or saturation).
//   - Zero velocity is a legal value.
//   - ptr wraps NUM_BALLS-1 -> 0.
//   Reset mid-operation:
//   - All pending/latched requests are dropped. No write is issued after release until a
//     new reqValid is captured.
//
// TESTING
//   1. Ball 2 req at t with vel (-5,+7) -> wrEn=1, hitSound=1 in t+3 only;
//      wrIdx=2, wrVelX=-5, wrVelY=7.
//   2. reqValid[1] held 40 cycles, vel changing -> exactly one write, carrying the
//      first-cycle vel. Then startOfFrame and hold again -> exactly one more write.
//   3. reqValid=4'b1011 on one cycle, no prior grants -> writes idx 0,1,3 at t+3, t+5,
//      t+7; busy low from t+8.
//   4. After the idx 3 write (ptr=3), startOfFrame, then req 0 and 3 together ->
//      idx 0 first, then 3 (3 is not rescanned first).
//   5. startOfFrame on the same edge as the ball-2 WRITE -> lock[2]=0. A new ball-2 req
//      2 cycles later produces a write.
//   6. resetN low while state=WRITE with 2 pending -> wrEn/busy 0 immediately; no writes
//      for 10 cycles after release with reqValid=0.

Source files
------------

// File: rtl/collision_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// collision_arbiter_if
//   Request/write bus between border-collision units and the velocity bank.
//   Revision: 1.0
// ----------------------------------------------------------------------------
interface collision_arbiter_if #(
    parameter int NUM_BALLS = 4,
    parameter int VEL_W     = 11
);
    localparam int IDX_W = $clog2(NUM_BALLS);

    logic                          startOfFrame;
    logic [NUM_BALLS-1:0]          reqValid;
    logic [NUM_BALLS*VEL_W-1:0]    reqVelX;
    logic [NUM_BALLS*VEL_W-1:0]    reqVelY;
    logic                          wrEn;
    logic [IDX_W-1:0]              wrIdx;
    logic signed [VEL_W-1:0]       wrVelX;
    logic signed [VEL_W-1:0]       wrVelY;
    logic                          hitSound;
    logic                          busy;

    modport master (
        output startOfFrame, reqValid, reqVelX, reqVelY,
        input  wrEn, wrIdx, wrVelX, wrVelY, hitSound, busy
    );

    modport slave (
        input  startOfFrame, reqValid, reqVelX, reqVelY,
        output wrEn, wrIdx, wrVelX, wrVelY, hitSound, busy
    );
endinterface
`default_nettype wire

// File: rtl/collision_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// collision_arbiter
//   Accepts one collision per ball per frame and serialises the velocity
//   updates round-robin onto the single velocity-bank write port.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module collision_arbiter #(
    parameter int NUM_BALLS = 4,
    parameter int VEL_W     = 11
) (
    input  wire logic          clk,
    input  wire logic          resetN,
    collision_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_BALLS);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_do_grant;
    logic                 w_do_write;

    logic [NUM_BALLS-1:0] r_pend;
    logic [NUM_BALLS-1:0] r_lock;
    logic [NUM_BALLS-1:0] w_capture;
    logic [VEL_W-1:0]     r_slot_x [NUM_BALLS];
    logic [VEL_W-1:0]     r_slot_y [NUM_BALLS];

    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     w_rr_idx;
    logic                 w_rr_found;
    logic [IDX_W-1:0]     w_cand [NUM_BALLS];

    logic                 r_wr_en;
    logic                 r_hit;
    logic                 r_busy;
    logic [IDX_W-1:0]     r_wr_idx;
    logic [VEL_W-1:0]     r_wr_vel_x;
    logic [VEL_W-1:0]     r_wr_vel_y;

    // Candidate k is the k-th ball after the last one written, wrapping.
    generate
        for (genvar k = 0; k < NUM_BALLS; k++) begin : g_cand
            assign w_cand[k] = IDX_W'((int'(r_ptr) + k + 1) % NUM_BALLS);
        end
    endgenerate

    always_comb begin
        w_rr_idx   = r_ptr;
        w_rr_found = 1'b0;
        for (int k = 0; k < NUM_BALLS; k++) begin
            if (!w_rr_found && r_pend[w_cand[k]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[k];
            end
        end
    end

    // A ball already pending or locked this frame keeps its latched request.
    assign w_capture = bus.reqValid & ~r_pend & ~r_lock;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_do_grant   = 1'b0;
        w_do_write   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rr_found) begin
                    w_do_grant   = 1'b1;
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_do_write   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pend <= '0;
            r_lock <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_slot_x[i] <= '0;
                r_slot_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (w_capture[i]) begin
                    r_pend[i]   <= 1'b1;
                    r_slot_x[i] <= bus.reqVelX[i*VEL_W +: VEL_W];
                    r_slot_y[i] <= bus.reqVelY[i*VEL_W +: VEL_W];
                end
            end
            if (w_do_write) begin
                r_pend[r_grant_idx] <= 1'b0;
                r_lock[r_grant_idx] <= 1'b1;
            end
            // Frame start wins over a lock set by a write on the same edge.
            if (bus.startOfFrame) begin
                r_lock <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ptr       <= IDX_W'(NUM_BALLS - 1);
            r_grant_idx <= '0;
            r_wr_en     <= 1'b0;
            r_hit       <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_vel_x  <= '0;
            r_wr_vel_y  <= '0;
        end else begin
            r_wr_en <= w_do_write;
            r_hit   <= w_do_write;
            r_busy  <= (|r_pend) || (r_state != S_IDLE);
            if (w_do_grant) begin
                r_grant_idx <= w_rr_idx;
            end
            if (w_do_write) begin
                r_wr_idx   <= r_grant_idx;
                r_wr_vel_x <= r_slot_x[r_grant_idx];
                r_wr_vel_y <= r_slot_y[r_grant_idx];
                r_ptr      <= r_grant_idx;
            end
        end
    end

    assign bus.wrEn     = r_wr_en;
    assign bus.hitSound = r_hit;
    assign bus.busy     = r_busy;
    assign bus.wrIdx    = r_wr_idx;
    assign bus.wrVelX   = r_wr_vel_x;
    assign bus.wrVelY   = r_wr_vel_y;
endmodule
`default_nettype wire

// File: tb/tb_collision_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_collision_arbiter
//   Directed scenarios plus randomized traffic against a transaction-level model.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_collision_arbiter;
    localparam int N = 4;
    localparam int W = 11;

    logic clk = 1'b0;
    logic resetN;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    collision_arbiter_if #(.NUM_BALLS(N), .VEL_W(W)) bus ();

    collision_arbiter #(.NUM_BALLS(N), .VEL_W(W)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    // Reference model: sets of pending/locked balls, latched slots, and the
    // ball whose write lands on the next edge (-1 when none is granted).
    bit         m_pend [N];
    bit         m_lock [N];
    bit         n_pend [N];
    bit         n_lock [N];
    logic [W-1:0] m_sx [N];
    logic [W-1:0] m_sy [N];
    int         m_ptr;
    int         m_sel;
    int         n_sel;
    logic       exp_wrEn, exp_hit, exp_busy;
    logic [1:0] exp_idx;
    logic [W-1:0] exp_vx, exp_vy;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_lock[i] = 0; m_sx[i] = '0; m_sy[i] = '0;
            end
            m_ptr = N - 1; m_sel = -1;
            exp_wrEn = 0; exp_hit = 0; exp_busy = 0; exp_idx = '0; exp_vx = '0; exp_vy = '0;
        end else begin
            exp_busy = (m_sel >= 0);
            for (int i = 0; i < N; i++) begin
                if (m_pend[i]) exp_busy = 1;
                n_pend[i] = m_pend[i];
                n_lock[i] = m_lock[i];
            end
            n_sel = -1;
            exp_wrEn = 0;
            if (m_sel >= 0) begin
                exp_wrEn = 1;
                exp_idx  = 2'(m_sel);
                exp_vx   = m_sx[m_sel];
                exp_vy   = m_sy[m_sel];
                n_pend[m_sel] = 0;
                n_lock[m_sel] = 1;
                m_ptr = m_sel;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (n_sel < 0 && m_pend[(m_ptr + k) % N]) n_sel = (m_ptr + k) % N;
            end
            exp_hit = exp_wrEn;
            for (int i = 0; i < N; i++) begin
                if (bus.reqValid[i] && !m_pend[i] && !m_lock[i]) begin
                    n_pend[i] = 1;
                    m_sx[i] = bus.reqVelX[i*W +: W];
                    m_sy[i] = bus.reqVelY[i*W +: W];
                end
                if (bus.startOfFrame) n_lock[i] = 0;
                m_pend[i] = n_pend[i];
                m_lock[i] = n_lock[i];
            end
            m_sel = n_sel;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.startOfFrame = 1'b0;
        bus.reqValid     = '0;
        bus.reqVelX      = '0;
        bus.reqVelY      = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetN = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.wrEn, bus.hitSound, bus.busy, bus.wrIdx, bus.wrVelX, bus.wrVelY} !== '0) begin
            bad++; $display("FAIL reset_held: got %b/%b/%b idx=%0d required all zero", bus.wrEn, bus.hitSound, bus.busy, bus.wrIdx);
        end
        resetN = 1'b1;
        repeat (2) tick();
        total++;
        if ({bus.wrEn, bus.hitSound, bus.busy, bus.wrIdx, bus.wrVelX, bus.wrVelY} !== '0) begin
            bad++; $display("FAIL reset_release: got %b/%b/%b idx=%0d required all zero", bus.wrEn, bus.hitSound, bus.busy, bus.wrIdx);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] c_vx = -11'sd5;
        logic [W-1:0] c_vy = 11'sd7;
        apply_reset();
        bus.reqValid = 4'b0100;
        bus.reqVelX[2*W +: W] = c_vx;
        bus.reqVelY[2*W +: W] = c_vy;
        tick();
        clear_inputs();
        for (int j = 0; j < 4; j++) begin
            total++;
            if ({bus.wrEn, bus.hitSound} !== ((j == 2) ? 2'b11 : 2'b00)) begin
                bad++; $display("FAIL single_strobe j=%0d: got wrEn=%b hit=%b required %b", j, bus.wrEn, bus.hitSound, (j == 2));
            end
            if (j >= 2) begin
                total++;
                if ({bus.wrIdx, bus.wrVelX, bus.wrVelY} !== {2'd2, c_vx, c_vy}) begin
                    bad++; $display("FAIL single_data j=%0d: got idx=%0d vx=%0d vy=%0d required 2/-5/7", j, bus.wrIdx, bus.wrVelX, bus.wrVelY);
                end
            end
            tick();
        end
    endtask

    task automatic test_hold();
        int writes;
        logic [W-1:0] vx;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) apply_reset();
            else begin bus.startOfFrame = 1'b1; tick(); bus.startOfFrame = 1'b0; end
            writes = 0; vx = '0;
            for (int j = 0; j < 44; j++) begin
                bus.reqValid[1] = (j < 40);
                bus.reqVelX[1*W +: W] = W'(100 * (f + 1) + j);
                bus.reqVelY[1*W +: W] = W'(-j);
                tick();
                if (bus.wrEn) begin writes++; vx = bus.wrVelX; end
            end
            clear_inputs();
            total++;
            if (writes !== 1 || vx !== W'(100 * (f + 1))) begin
                bad++; $display("FAIL hold_frame%0d: got %0d writes vx=%0d required 1 write vx=%0d", f, writes, vx, 100 * (f + 1));
            end
        end
    endtask

    task automatic test_multi();
        apply_reset();
        for (int i = 0; i < N; i++) bus.reqVelX[i*W +: W] = W'(10 * i + 1);
        bus.reqValid = 4'b1011;
        tick();
        clear_inputs();
        for (int j = 0; j <= 8; j++) begin
            logic ew, eb;
            ew = (j == 2 || j == 4 || j == 6);
            eb = (j >= 1 && j <= 6);
            total++;
            if ({bus.wrEn, bus.busy} !== {ew, eb}) begin
                bad++; $display("FAIL multi_timing j=%0d: got wrEn=%b busy=%b required %b/%b", j, bus.wrEn, bus.busy, ew, eb);
            end
            if (ew) begin
                logic [1:0] ei;
                ei = (j == 2) ? 2'd0 : (j == 4) ? 2'd1 : 2'd3;
                total++;
                if ({bus.wrIdx, bus.wrVelX} !== {ei, W'(10 * ei + 1)}) begin
                    bad++; $display("FAIL multi_data j=%0d: got idx=%0d vx=%0d required %0d/%0d", j, bus.wrIdx, bus.wrVelX, ei, 10 * ei + 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_rr_wrap();
        int order [4];
        int cnt = 0;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        bus.reqValid = 4'b1001;
        tick();
        clear_inputs();
        for (int j = 0; j < 8; j++) begin
            if (bus.wrEn && cnt < 4) begin order[cnt] = int'(bus.wrIdx); cnt++; end
            tick();
        end
        total++;
        if (cnt !== 2 || order[0] !== 0 || order[1] !== 3) begin
            bad++; $display("FAIL rr_wrap: got %0d writes first=%0d second=%0d required 2 writes 0 then 3", cnt, order[0], order[1]);
        end
    endtask

    task automatic test_sof_same_edge();
        int writes = 0;
        apply_reset();
        bus.reqValid = 4'b0100;
        tick();
        bus.reqValid = '0;
        tick();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        total++;
        if ({bus.wrEn, bus.wrIdx} !== {1'b1, 2'd2}) begin
            bad++; $display("FAIL sof_edge_write: got wrEn=%b idx=%0d required 1/2", bus.wrEn, bus.wrIdx);
        end
        tick();
        bus.reqValid = 4'b0100;
        bus.reqVelX[2*W +: W] = W'(333);
        tick();
        clear_inputs();
        for (int j = 0; j < 6; j++) begin
            if (bus.wrEn && bus.wrIdx == 2'd2 && bus.wrVelX == W'(333)) writes++;
            tick();
        end
        total++;
        if (writes !== 1) begin
            bad++; $display("FAIL sof_edge_unlock: got %0d writes required 1", writes);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        apply_reset();
        bus.reqValid = 4'b0011;
        tick();
        clear_inputs();
        tick();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL reset_mid_pre: got busy=%b required 1", bus.busy);
        end
        resetN = 1'b0;
        #1;
        total++;
        if ({bus.wrEn, bus.busy, bus.hitSound} !== 3'b000) begin
            bad++; $display("FAIL reset_mid_now: got wrEn=%b busy=%b hit=%b required 0", bus.wrEn, bus.busy, bus.hitSound);
        end
        tick();
        resetN = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (bus.wrEn || bus.busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL reset_mid_after: got %0d active cycles required 0", seen);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            total++;
            if ({bus.wrEn, bus.hitSound, bus.busy, bus.wrIdx, bus.wrVelX, bus.wrVelY} !==
                {exp_wrEn, exp_hit, exp_busy, exp_idx, exp_vx, exp_vy}) begin
                bad++;
                $display("FAIL random c=%0d: got en=%b hit=%b busy=%b idx=%0d vx=%0d vy=%0d required en=%b hit=%b busy=%b idx=%0d vx=%0d vy=%0d",
                         c, bus.wrEn, bus.hitSound, bus.busy, bus.wrIdx, bus.wrVelX, bus.wrVelY,
                         exp_wrEn, exp_hit, exp_busy, exp_idx, exp_vx, exp_vy);
            end
            if (!resetN) resetN = 1'b1;
            else if ($urandom_range(0, 499) == 0) resetN = 1'b0;
            bus.startOfFrame = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) bus.reqValid = N'($urandom) & N'($urandom);
            bus.reqVelX = (N*W)'({$urandom, $urandom});
            bus.reqVelY = (N*W)'({$urandom, $urandom});
            tick();
        end
        clear_inputs();
        resetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_multi();
        test_rr_wrap();
        test_sof_same_edge();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
